// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte-wide write FIFO: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Writes pass through a one-entry input register before landing in the FIFO.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 217,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic               r_par;
    logic               r_tx;
    logic               r_busy;
    logic               r_ready;
    logic               r_in_vld;
    logic [7:0]         r_in_data;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_bit_end;
    logic               w_last_stop;
    logic               w_stop_end;
    logic               w_pop;
    logic               w_to_idle;
    logic               w_accept;
    logic [CNT_W-1:0]   w_count_next;

    assign w_bit_end    = (r_baud == BAUD_LAST);
    assign w_last_stop  = (STOP_BITS > 1) ? r_stop_idx : 1'b1;
    assign w_stop_end   = (r_state == S_STOP) && w_bit_end && w_last_stop;
    assign w_pop        = (r_count != '0) && ((r_state == S_IDLE) || w_stop_end);
    assign w_to_idle    = !w_pop && ((r_state == S_IDLE) || w_stop_end);
    assign w_accept     = wr_valid_i && r_ready;
    assign w_count_next = r_count + CNT_W'(r_in_vld) - CNT_W'(w_pop);

    // Ready looks ahead at the byte sitting in the input register so the FIFO never overflows.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in_vld <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_in_vld <= w_accept;
            if (r_in_vld) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next + CNT_W'(w_accept)) < CNT_W'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_in_data <= wr_data_i;
        end
        if (r_in_vld) begin
            r_mem[r_wr_ptr] <= r_in_data;
        end
    end

    // Frame sequencer; tx is updated on the same edge as the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= !w_to_idle || (w_count_next != '0);
            if (w_pop) begin
                r_state <= S_START;
                r_baud  <= '0;
                r_shift <= r_mem[r_rd_ptr];
                r_par   <= (^r_mem[r_rd_ptr]) ^ 1'(PARITY_ODD);
                r_tx    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state   <= S_DATA;
                            r_baud    <= '0;
                            r_bit_idx <= '0;
                            r_tx      <= r_shift[0];
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_baud <= '0;
                            if (r_bit_idx == 3'd7) begin
                                if (PARITY_EN != 0) begin
                                    r_state <= S_PARITY;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state    <= S_STOP;
                                    r_stop_idx <= 1'b0;
                                    r_tx       <= 1'b1;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_shift   <= r_shift >> 1;
                                r_tx      <= r_shift[1];
                            end
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= S_STOP;
                            r_baud     <= '0;
                            r_stop_idx <= 1'b0;
                            r_tx       <= 1'b1;
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_baud <= '0;
                            if (w_stop_end) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_stop_idx <= 1'b1;
                            end
                            r_tx <= 1'b1;
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr_ready_o   = r_ready;
    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign fifo_count_o = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations at BAUD_DIV=4, a serial-line monitor
// that compares every frame cycle by cycle against a queue of expected bytes.
module tb_uart_tx_fifo;

    localparam int BD = 4;
    localparam int NBITS [4] = '{10, 11, 11, 11};
    localparam int PEN   [4] = '{0, 1, 1, 0};

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
        bit         b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wv;
    logic [7:0] wd   [4];
    logic [3:0] wr;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [4:0] cnt  [4];

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wv[0]), .wr_data_i(wd[0]), .wr_ready_o(wr[0]),
        .tx_o(tx[0]), .busy_o(busy[0]), .fifo_count_o(cnt[0]));
    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wv[1]), .wr_data_i(wd[1]), .wr_ready_o(wr[1]),
        .tx_o(tx[1]), .busy_o(busy[1]), .fifo_count_o(cnt[1]));
    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wv[2]), .wr_data_i(wd[2]), .wr_ready_o(wr[2]),
        .tx_o(tx[2]), .busy_o(busy[2]), .fifo_count_o(cnt[2]));
    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_2stop (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wv[3]), .wr_data_i(wd[3]), .wr_ready_o(wr[3]),
        .tx_o(tx[3]), .busy_o(busy[3]), .fifo_count_o(cnt[3]));

    task automatic check(input string name, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Called just after a rising edge; the byte is accepted on the next rising edge.
    task automatic wr_byte(input int i, input logic [7:0] d, input logic p, input bit b2b, input bit expect_frame);
        exp_t e;
        wv[i] = 1'b1;
        wd[i] = d;
        @(posedge clk);
        #1;
        wv[i] = 1'b0;
        if (expect_frame) begin
            e.id = i; e.data = d; e.par = p; e.b2b = b2b;
            sbq.push_back(e);
        end
    endtask

    // k counts samples taken after successive edges, k=0 being the first edge after the call.
    task automatic measure(input int i, input int limit, output int fall, output int drop, output int peak);
        fall = -1; drop = -1; peak = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (int'(cnt[i]) > peak) peak = int'(cnt[i]);
            if (fall < 0 && tx[i] == 1'b0) fall = k;
            if (fall >= 0 && busy[i] == 1'b0) begin
                drop = k;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Serial-line monitor: pops the expected byte at each start bit and checks every frame cycle.
    int         mcyc     [4];
    bit         mact     [4];
    bit         mok      [4];
    logic [7:0] mdata    [4];
    exp_t       mexp     [4];
    int         last_end [4];
    int         tcyc = 0;

    always @(negedge clk) begin
        int   bn;
        logic eb;
        tcyc++;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mact[i] = 1'b0;
            end else begin
                if (!mact[i] && tx[i] == 1'b0) begin
                    mact[i] = 1'b1; mcyc[i] = 0; mok[i] = 1'b1; mdata[i] = 8'h00;
                    if (sbq.size() == 0) begin
                        check("unexpected_frame", 1'b0, i, -1);
                        mexp[i].id = i; mexp[i].data = 8'h00; mexp[i].par = 1'b0; mexp[i].b2b = 1'b0;
                    end else begin
                        mexp[i] = sbq.pop_front();
                        check("frame_owner", mexp[i].id == i, i, mexp[i].id);
                        if (mexp[i].b2b) check("idle_gap", (tcyc - last_end[i]) == 1, tcyc - last_end[i] - 1, 0);
                    end
                end
                if (mact[i]) begin
                    bn = mcyc[i] / BD;
                    if (bn == 0) eb = 1'b0;
                    else if (bn <= 8) eb = mexp[i].data[3'(bn - 1)];
                    else if (bn == 9 && PEN[i] != 0) eb = mexp[i].par;
                    else eb = 1'b1;
                    if (tx[i] !== eb) mok[i] = 1'b0;
                    if (bn >= 1 && bn <= 8 && (mcyc[i] % BD) == BD / 2) mdata[i][3'(bn - 1)] = tx[i];
                    mcyc[i]++;
                    if (mcyc[i] == NBITS[i] * BD) begin
                        mact[i] = 1'b0;
                        last_end[i] = tcyc;
                        check("frame", mok[i] && (mdata[i] == mexp[i].data), int'(mdata[i]), int'(mexp[i].data));
                    end
                end
            end
        end
    end

    initial begin
        int fall, drop, peak, acc, phase;
        bit do_acc;
        for (int i = 0; i < 4; i++) begin
            wd[i] = 8'h00;
            last_end[i] = 0;
            mact[i] = 1'b0;
        end
        wv  = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_tx", tx[i] == 1'b1, int'(tx[i]), 1);
            check("reset_ready", wr[i] == 1'b1, int'(wr[i]), 1);
            check("reset_busy", busy[i] == 1'b0, int'(busy[i]), 0);
            check("reset_count", cnt[i] == 5'd0, int'(cnt[i]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T1: single 8N1 frame
        wr_byte(0, 8'h55, 1'b0, 1'b0, 1'b1);
        measure(0, 200, fall, drop, peak);
        check("t1_latency", fall == 2, fall, 2);
        check("t1_frame_len", drop - fall == 40, drop - fall, 40);
        check("t1_count_peak", peak == 1, peak, 1);
        check("t1_idle_tx", tx[0] == 1'b1, int'(tx[0]), 1);

        // T2: parity even then odd
        wr_byte(1, 8'hA3, 1'b0, 1'b0, 1'b1);
        measure(1, 200, fall, drop, peak);
        check("t2_even_len", drop - fall == 44, drop - fall, 44);
        wr_byte(2, 8'hA3, 1'b1, 1'b0, 1'b1);
        measure(2, 200, fall, drop, peak);
        check("t2_odd_len", drop - fall == 44, drop - fall, 44);

        // T3: three back-to-back frames
        wr_byte(0, 8'h01, 1'b0, 1'b0, 1'b1);
        wr_byte(0, 8'h02, 1'b0, 1'b1, 1'b1);
        wr_byte(0, 8'h03, 1'b0, 1'b1, 1'b1);
        measure(0, 400, fall, drop, peak);
        check("t3_first_fall", fall == 0, fall, 0);
        check("t3_total_len", drop - fall == 120, drop - fall, 120);

        // T6: two stop bits
        wr_byte(3, 8'hFF, 1'b0, 1'b0, 1'b1);
        wr_byte(3, 8'h00, 1'b0, 1'b1, 1'b1);
        measure(3, 400, fall, drop, peak);
        check("t6_first_fall", fall == 1, fall, 1);
        check("t6_total_len", drop - fall == 88, drop - fall, 88);

        // T4: fill FIFO while the first frame is in flight
        wr_byte(0, 8'h10, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("t4_frame_started", tx[0] == 1'b0, int'(tx[0]), 0);
        wv[0] = 1'b1;
        wd[0] = 8'h20;
        acc   = 0;
        phase = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 20) begin
                check("t4_accepted", acc == 16, acc, 16);
                check("t4_count_full", cnt[0] == 5'd16, int'(cnt[0]), 16);
                check("t4_ready_low", wr[0] == 1'b0, int'(wr[0]), 0);
                phase = 1;
            end else if (phase == 1 && cnt[0] != 5'd16) begin
                check("t4_count_after_pop", cnt[0] == 5'd15, int'(cnt[0]), 15);
                check("t4_ready_after_pop", wr[0] == 1'b1, int'(wr[0]), 1);
                phase = 2;
            end else if (phase == 3) begin
                check("t4_ready_refull", wr[0] == 1'b0, int'(wr[0]), 0);
                phase = 4;
            end
            do_acc = wv[0] && wr[0];
            @(posedge clk);
            #1;
            if (do_acc) begin
                exp_t e;
                e.id = 0; e.data = wd[0]; e.par = 1'b0; e.b2b = 1'b1;
                sbq.push_back(e);
                acc++;
                wd[0] = wd[0] + 8'd1;
                if (phase == 2) begin
                    wv[0] = 1'b0;
                    phase = 3;
                end
            end
            if (phase == 4) break;
        end
        wv[0] = 1'b0;
        check("t4_sequence_done", phase == 4, phase, 4);
        measure(0, 1200, fall, drop, peak);
        check("t4_drained", drop >= 0, drop, 0);

        // T5: reset in the middle of a data bit with bytes queued
        wr_byte(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) wr_byte(0, 8'h80 + 8'(b), 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_tx_high", tx[0] == 1'b1, int'(tx[0]), 1);
        check("t5_count_zero", cnt[0] == 5'd0, int'(cnt[0]), 0);
        check("t5_busy_zero", busy[0] == 1'b0, int'(busy[0]), 0);
        check("t5_ready", wr[0] == 1'b1, int'(wr[0]), 1);
        peak = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx[0] == 1'b0 || busy[0] == 1'b1) peak++;
        end
        check("t5_stays_idle", peak == 0, peak, 0);

        check("scoreboard_drained", sbq.size() == 0, sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
